// File: rtl/sr_block_arbiter.sv
// Block-granular round-robin arbiter in front of the sign-reduction engine.
// A requester is granted for a whole BLK_BEATS block. The source of each
// finished block is queued in a small tag FIFO, so engine results can be
// labelled with the requester that produced them.
//
// Handshakes: a beat transfers on a clock edge only when valid and ready are
// both high. Valid never depends on ready. req_ready_o[gnt] is eng_ready_i
// passed straight through. All other ready bits stay low.
module sr_block_arbiter #(
   parameter int NREQ      = 4,
   parameter int BLK_BEATS = 16,
   parameter int TAG_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [64*NREQ-1:0] req_data_i,
   output logic [NREQ-1:0]   req_ready_o,
   output logic [63:0]       eng_data_o,
   output logic              eng_valid_o,
   input  logic              eng_ready_i,
   input  logic [63:0]       eng_data_i,
   input  logic              eng_flag_i,
   input  logic              eng_d_valid_i,
   input  logic              eng_s_valid_i,
   output logic [63:0]       out_data_o,
   output logic              out_d_valid_o,
   output logic              out_flag_o,
   output logic              out_s_valid_o,
   output logic [1:0]        out_src_o,
   output logic              err_o
);

   localparam int AW = $clog2(TAG_DEPTH);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t        state;
   logic [1:0]    gnt;
   logic [1:0]    last_gnt;
   logic [3:0]    beat_cnt;

   logic [1:0]    tag_mem [TAG_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   tag_cnt;
   logic [AW:0]   tag_cnt_next;
   logic [1:0]    tag_head;

   logic          fifo_full;
   logic          fifo_empty;
   logic          beat_hs;
   logic          last_beat;
   logic          push;
   logic          push_ok;
   logic          pop;
   logic          full_after;

   logic [1:0]    arb_base;
   logic [1:0]    arb_idx;
   logic [1:0]    cand;
   logic          arb_found;

   assign fifo_full  = (tag_cnt == (AW+1)'(TAG_DEPTH));
   assign fifo_empty = (tag_cnt == '0);
   assign tag_head   = tag_mem[rd_ptr];

   assign beat_hs    = eng_valid_o & eng_ready_i;
   assign last_beat  = beat_hs && (beat_cnt == 4'(BLK_BEATS - 1));
   assign push       = last_beat;
   // A push into a full FIFO is accepted only if a pop frees a slot in the same cycle
   assign push_ok    = push & (~fifo_full | pop);
   assign pop        = eng_s_valid_i & ~fifo_empty;
   assign full_after = (tag_cnt_next == (AW+1)'(TAG_DEPTH));

   // On the last beat the block owner becomes last_gnt, so the search starts after gnt
   assign arb_base   = (state == BURST) ? gnt : last_gnt;

   // Round-robin search from arb_base+1, ending at arb_base itself
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = 2'((int'(arb_base) + i) % NREQ);
         if (!arb_found && req_valid_i[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged
   always_comb begin
      tag_cnt_next = tag_cnt;
      case ({push_ok, pop})
         2'b10:   tag_cnt_next = tag_cnt + 1'b1;
         2'b01:   tag_cnt_next = tag_cnt - 1'b1;
         default: tag_cnt_next = tag_cnt;
      endcase
   end

   // Steer the granted requester to the engine; everything is quiet while IDLE
   always_comb begin
      eng_data_o  = '0;
      eng_valid_o = 1'b0;
      req_ready_o = '0;
      if (state == BURST) begin
         for (int k = 0; k < NREQ; k++) begin
            if (gnt == 2'(k)) begin
               eng_data_o     = req_data_i[64*k +: 64];
               eng_valid_o    = req_valid_i[k];
               req_ready_o[k] = eng_ready_i;
            end
         end
      end
   end

   // Grant FSM: hold the grant for a full block and re-arbitrate only at the block end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         last_gnt <= 2'(NREQ - 1);
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_found && !fifo_full) begin
                  gnt   <= arb_idx;
                  state <= BURST;
               end
            end
            BURST: begin
               if (beat_hs) begin
                  if (last_beat) begin
                     beat_cnt <= '0;
                     last_gnt <= gnt;
                     if (!full_after && arb_found) begin
                        gnt <= arb_idx;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag storage is data only; validity is tracked by the pointers and count
   always_ff @(posedge clk) begin
      if (push_ok) begin
         tag_mem[wr_ptr] <= gnt;
      end
   end

   // Tag FIFO pointers, occupancy and the sticky protocol error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         tag_cnt <= '0;
         err_o   <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         tag_cnt <= tag_cnt_next;
         if ((eng_s_valid_i & fifo_empty) | (push & fifo_full & ~pop)) begin
            err_o <= 1'b1;
         end
      end
   end

   // One register stage on the engine results, tagged with the FIFO head
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_o    <= '0;
         out_d_valid_o <= 1'b0;
         out_flag_o    <= 1'b0;
         out_s_valid_o <= 1'b0;
         out_src_o     <= '0;
      end else begin
         out_d_valid_o <= eng_d_valid_i;
         out_s_valid_o <= eng_s_valid_i;
         if (eng_d_valid_i) begin
            out_data_o <= eng_data_i;
         end
         if (eng_s_valid_i) begin
            out_flag_o <= eng_flag_i;
         end
         if ((eng_d_valid_i | eng_s_valid_i) & ~fifo_empty) begin
            out_src_o <= tag_head;
         end
      end
   end

endmodule

// File: doc/sr_block_arbiter.md
SR_BLOCK_ARBITER -- requirements
Module: sr_block_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NREQ, 4, number of requesters; supported range 2..4.
- BLK_BEATS, 16, beats per sign-reduction block; SHALL equal the engine block length.
- TAG_DEPTH, 4, depth of the block-source tag FIFO; power of 2, minimum 2.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- req_valid_i, in, NREQ, per-requester beat valid.
- req_data_i, in, 64*NREQ, per-requester beat; requester k occupies bits [64k+63:64k].
- req_ready_o, out, NREQ, per-requester accept.
- eng_data_o, out, 64, beat to the SR engine.
- eng_valid_o, out, 1, beat valid to the engine.
- eng_ready_i, in, 1, engine ready, passed through from downstream.
- eng_data_i, in, 64, packed engine output.
- eng_flag_i, in, 1, engine block fail flag.
- eng_d_valid_i, in, 1, engine packed-data valid.
- eng_s_valid_i, in, 1, engine block-status valid.
- out_data_o, out, 64, registered packed data.
- out_d_valid_o, out, 1, registered data valid.
- out_flag_o, out, 1, registered block flag.
- out_s_valid_o, out, 1, registered block-status valid.
- out_src_o, out, 2, requester index of the block producing the current outputs.
- err_o, out, 1, sticky protocol error.

Function
REQ-003 The FSM SHALL have two states. IDLE: no grant held, eng_valid_o=0, req_ready_o=0. BURST: grant gnt held.
REQ-004 Arbitration SHALL be round-robin at block granularity. Search starts at (last_gnt+1) mod NREQ. Only req_valid_i bits are eligible.
REQ-005 IDLE->BURST SHALL occur when any req_valid_i=1 and the tag FIFO is not full. gnt is registered, so the first beat is accepted no earlier than the next cycle.
REQ-006 In BURST, the datapath SHALL be:
- eng_data_o = req_data_i[gnt]
- eng_valid_o = req_valid_i[gnt]
- req_ready_o[gnt] = eng_ready_i
- all other req_ready_o bits = 0
REQ-007 A beat SHALL be counted only on eng_valid_o & eng_ready_i. The counter is 4 bits, wraps at BLK_BEATS-1 to 0, and resets to 0.
REQ-008 The grant SHALL be held for the full block. A requester dropping valid mid-block creates a bubble only; there is no abort and no re-arbitration.
REQ-009 On the last-beat handshake, the arbiter SHALL:
- push gnt into the tag FIFO and set last_gnt=gnt;
- if the FIFO is not full after the push and any request is valid, re-arbitrate in the same cycle and stay in BURST with the new gnt (zero-bubble back-to-back blocks);
- otherwise go to IDLE.
REQ-010 Output registering: out_data_o, out_d_valid_o, out_flag_o and out_s_valid_o SHALL be eng_* inputs delayed by one register stage. out_data_o and out_flag_o SHALL update only when their valid is high.
REQ-011 out_src_o SHALL be the tag-FIFO head registered alongside the outputs, and SHALL be valid whenever out_d_valid_o or out_s_valid_o is 1.
REQ-012 The tag FIFO SHALL pop on eng_s_valid_i. A simultaneous push and pop SHALL be legal at any occupancy, including full, with occupancy unchanged.
REQ-013 Either of the following SHALL set err_o=1 until reset:
- eng_s_valid_i while the FIFO is empty (no pop occurs);
- a push while full without a simultaneous pop (cannot occur given REQ-005/009; checked defensively).
REQ-014 Width rule: the NREQ index SHALL be zero-extended to 2 bits on out_src_o.

Reset
REQ-015 rst_n low SHALL asynchronously force: state=IDLE, gnt=0, last_gnt=NREQ-1, beat count=0, FIFO empty, and all outputs 0.
REQ-016 Reset mid-block SHALL discard the partial block and all pending tags. The first grant after reset SHALL go to the lowest-indexed valid requester. The engine shares rst_n, so block alignment is restored.

Verification
REQ-017 Single requester: req_valid_i=0001, eng_ready_i=1 constantly ->
- first handshake 1 cycle after valid;
- 16 consecutive beats;
- out_s_valid_o 2 cycles after beat 15, with out_src_o=0.
REQ-018 All four requesters valid continuously -> block grant order 0,1,2,3,0. No bubble between blocks, so 64 beats take 64 cycles after the first.
REQ-019 Requester 2 drops valid for 3 cycles at beat 7 while requester 1 is also valid -> gnt stays 2, the block completes with 16 beats, then requester 1 is granted.
REQ-020 Backpressure with eng_ready_i toggling 1010..., and a status return withheld until 4 tags are pending -> no new grant until a pop. Tag order is preserved and err_o stays 0.
REQ-021 eng_s_valid_i pulsed with the FIFO empty -> err_o=1 next cycle and held. rst_n asserted at beat 9 -> all outputs 0 immediately, and the restart grants requester 0.
